// File: rtl/div_pkg.sv
// Shared encodings and defaults for the restoring divider.
// Used by the sequencing FSM, its iteration counter and the remainder register.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_FIX   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic load;
        logic sll;
        logic srl;
        logic busy;
        logic rdy;
    } ctrl_out_t;

    function automatic logic can_start(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the shift/subtract phase.
// last flags the final iteration; the count returns to 0 instead of wrapping.
module div_iter_counter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    assign last = (cnt == LAST_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/divider_ctrl.sv
// Sequencing FSM for the unsigned restoring divider (load, WIDTH shifts, fix-up).
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor skips the shift and fix-up phases.
module divider_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] divisor,
    output logic             w_ctrl_reg2,
    output logic             SLL_ctrl,
    output logic             SRL_ctrl,
    output logic             busy,
    output logic             rdy,
    output logic             div_zero
);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             accept;
    logic             zero_q;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;
    ctrl_out_t        out_d;

    assign accept  = start && can_start(state);
    assign cnt_en  = (state == ST_SHIFT);
    assign cnt_clr = (state != ST_SHIFT);

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= (divisor == '0);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
`ifdef DIV_ZERO_SHORTCUT_EN
                state_nx = zero_q ? ST_DONE : ST_SHIFT;
`else
                state_nx = ST_SHIFT;
`endif
            end
            ST_SHIFT: begin
                if (cnt_last) state_nx = ST_FIX;
            end
            ST_FIX: begin
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = accept ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d      = '0;
        out_d.load = (state == ST_LOAD);
        out_d.sll  = (state == ST_SHIFT);
        out_d.srl  = (state == ST_FIX);
        out_d.busy = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_FIX);
        out_d.rdy  = (state == ST_DONE);
    end

    // div_zero moves with rdy so a back-to-back start cannot clobber the result flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ctrl_reg2 <= 1'b0;
            SLL_ctrl    <= 1'b0;
            SRL_ctrl    <= 1'b0;
            busy        <= 1'b0;
            rdy         <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            w_ctrl_reg2 <= out_d.load;
            SLL_ctrl    <= out_d.sll;
            SRL_ctrl    <= out_d.srl;
            busy        <= out_d.busy;
            rdy         <= out_d.rdy;
            if (out_d.rdy) div_zero <= zero_q;
        end
    end

    a_cnt_idle: assert property (
        @(posedge clk) disable iff (rst) (state != ST_SHIFT) |-> (cnt == '0)
    );

endmodule

// File: tb/tb_divider_ctrl.sv
// Randomised scoreboard bench for divider_ctrl with a behavioural remainder register.
// Expected strobe windows and rdy timing derive from accepted start times.
module tb_divider_ctrl;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] divisor;
    logic [W-1:0] dividend;
    logic         w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy, div_zero;

    always #5 clk = ~clk;

    divider_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .divisor     (divisor),
        .w_ctrl_reg2 (w_ctrl_reg2),
        .SLL_ctrl    (SLL_ctrl),
        .SRL_ctrl    (SRL_ctrl),
        .busy        (busy),
        .rdy         (rdy),
        .div_zero    (div_zero)
    );

    typedef struct {
        int          e;
        bit          zero;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t         ops[$];
    op_t         sb[$];
    op_t         o_new;
    op_t         o_chk;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          next_acc = 0;
    logic [64:0] rem;
    logic [31:0] dp_a, dp_b;
    bit          ew, es, er, eb, ey;

    function automatic int lat_of(input bit z);
`ifdef DIV_ZERO_SHORTCUT_EN
        if (z) return 2;
`endif
        return LAT;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a start is taken whenever the previous operation has reached its rdy slot
    always @(posedge clk) begin
        cyc++;
        if (!rst && start && cyc >= next_acc) begin
            o_new.e    = cyc;
            o_new.zero = (divisor == 0);
            o_new.a    = dividend;
            o_new.b    = divisor;
            ops.push_back(o_new);
            sb.push_back(o_new);
            next_acc = cyc + lat_of(o_new.zero);
            dp_a = dividend;
            dp_b = divisor;
        end
    end

    always @(posedge rst) begin
        ops.delete();
        sb.delete();
        next_acc = 0;
    end

    always @(negedge clk) begin
        ew = 0; es = 0; er = 0; eb = 0; ey = 0;
        foreach (ops[i]) begin
            int d, l;
            d = cyc - ops[i].e;
            l = lat_of(ops[i].zero);
            if (d == 1) ew = 1;
            if (l == LAT && d >= 2 && d <= W + 1) es = 1;
            if (l == LAT && d == W + 2) er = 1;
            if (d >= 1 && d < l) eb = 1;
            if (d == l) ey = 1;
        end
        while (ops.size() > 0 && cyc - ops[0].e >= lat_of(ops[0].zero))
            void'(ops.pop_front());
        if (!rst) begin
            chk("w_ctrl_reg2", w_ctrl_reg2, ew);
            chk("SLL_ctrl", SLL_ctrl, es);
            chk("SRL_ctrl", SRL_ctrl, er);
            chk("busy", busy, eb);
            chk("rdy", rdy, ey);
            if (rdy) begin
                if (sb.size() == 0) begin
                    chk("rdy_unexpected", 1, 0);
                end else begin
                    o_chk = sb.pop_front();
                    chk("rdy_cycle", cyc, o_chk.e + lat_of(o_chk.zero));
                    chk("div_zero", div_zero, o_chk.zero);
                    if (!o_chk.zero) begin
                        chk("quotient", rem[31:0], o_chk.a / o_chk.b);
                        chk("remainder", rem[63:32], o_chk.a % o_chk.b);
                    end
                end
            end
        end
        // remainder register samples the strobes on negedge
        if (rst) begin
            rem = '0;
        end else if (w_ctrl_reg2) begin
            rem = {32'b0, dp_a, 1'b0};
        end else if (SLL_ctrl) begin
            if (rem[64:32] >= {1'b0, dp_b}) begin
                rem[64:32] = rem[64:32] - {1'b0, dp_b};
                rem = {rem[63:0], 1'b1};
            end else begin
                rem = {rem[63:0], 1'b0};
            end
        end else if (SRL_ctrl) begin
            rem[64:32] = rem[64:32] >> 1;
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        divisor = '0;
        dividend = '0;
        repeat (3) @(negedge clk);
        chk("rst_w", w_ctrl_reg2, 0);
        chk("rst_sll", SLL_ctrl, 0);
        chk("rst_srl", SRL_ctrl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_dz", div_zero, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        op(32'd100, 32'd7);
        drain();
        op(32'hFFFF_FFFF, 32'd1);
        drain();

        // start re-pulsed in the middle of the shift phase
        op(32'd5000, 32'd13);
        repeat (5) @(negedge clk);
        start = 1'b1;
        dividend = 32'd1;
        divisor = 32'd1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held across the done slot
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        repeat (20) @(negedge clk);
        dividend = 32'd12345;
        divisor = 32'd10;
        repeat (16) @(negedge clk);
        start = 1'b0;
        drain();
        drain();

        op(32'd55, 32'd0);
        drain();

        // asynchronous reset mid-shift
        op(32'd77, 32'd5);
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_w", w_ctrl_reg2, 0);
        chk("mid_rst_sll", SLL_ctrl, 0);
        chk("mid_rst_srl", SRL_ctrl, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        op(32'd200, 32'd9);
        drain();

        repeat (1500) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) == 0);
            dividend = $urandom;
            if ($urandom_range(0, 7) == 0)
                divisor = '0;
            else if ($urandom_range(0, 1) == 1)
                divisor = $urandom;
            else
                divisor = $urandom_range(1, 20);
        end
        start = 1'b0;
        drain();

        chk("drain_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
